// File: rtl/ft232h_pkg.sv
// Shared types and constants for the FT232H frame receiver.
package ft232h_pkg;

    // Byte reader (RD# timing) states.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LOW  = 2'd1,
        R_HIGH = 2'd2
    } rd_state_e;

    // Frame assembly states.
    typedef enum logic [1:0] {
        F_HUNT = 2'd0,
        F_CMD  = 2'd1,
        F_DATA = 2'd2,
        F_CHK  = 2'd3
    } frm_state_e;

    // Error codes reported on o_err_code.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_CHKSUM  = 2'd2;

endpackage

// File: rtl/ft232h_frame_rx_if.sv
// Pin and frame bus of the FT232H frame receiver.
// Handshake: there is no backpressure. o_data_ready and o_frame_err are
// single-cycle pulses; o_cmd/o_data are valid from the cycle o_data_ready is
// high until the next o_data_ready; o_err_code is valid with o_frame_err and
// held until the next error. The receiver never asserts both pulses together.
interface ft232h_frame_rx_if #(
    parameter int DATA_BYTES = 4
);
    logic                    i_rxf_n;
    logic [7:0]              i_data_in;
    logic                    o_rd_n;
    logic [7:0]              o_cmd;
    logic [8*DATA_BYTES-1:0] o_data;
    logic                    o_data_ready;
    logic                    o_frame_err;
    logic [1:0]              o_err_code;
    logic [1:0]              dbg_rd_state;
    logic [1:0]              dbg_frm_state;

    modport master (
        input  i_rxf_n, i_data_in,
        output o_rd_n, o_cmd, o_data, o_data_ready, o_frame_err, o_err_code,
        output dbg_rd_state, dbg_frm_state
    );

    modport slave (
        output i_rxf_n, i_data_in,
        input  o_rd_n, o_cmd, o_data, o_data_ready, o_frame_err, o_err_code,
        input  dbg_rd_state, dbg_frm_state
    );
endinterface

// File: rtl/ft232h_byte_rd.sv
// RXF# synchroniser and RD# timing FSM; emits one byte_vld pulse per read.
module ft232h_byte_rd
    import ft232h_pkg::*;
#(
    parameter int RD_LOW_CYC  = 2,
    parameter int RD_HIGH_CYC = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rxf_n,
    input  logic [7:0] i_data_in,
    output logic       o_rd_n,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic [1:0] o_state
);
    localparam logic [7:0] LOW_LAST  = 8'(RD_LOW_CYC - 1);
    localparam logic [7:0] HIGH_LAST = 8'(RD_HIGH_CYC - 1);

    logic      rxf_meta;
    logic      rxf_sync;
    rd_state_e state;
    logic [7:0] cnt;

    assign o_state = state;

    // Two-flop synchroniser for the asynchronous RXF# pin; idles as "empty".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rxf_meta <= 1'b1;
            rxf_sync <= 1'b1;
        end else begin
            rxf_meta <= i_rxf_n;
            rxf_sync <= rxf_meta;
        end
    end

    // RD# strobe: low for RD_LOW_CYC cycles, sample D on the last low cycle,
    // then high for RD_HIGH_CYC cycles. D itself needs no synchroniser since
    // it has been stable for the whole low phase when it is captured.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= R_IDLE;
            cnt        <= 8'd0;
            o_rd_n     <= 1'b1;
            o_byte     <= 8'd0;
            o_byte_vld <= 1'b0;
        end else begin
            o_byte_vld <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (!rxf_sync) begin
                        o_rd_n <= 1'b0;
                        cnt    <= 8'd0;
                        state  <= R_LOW;
                    end
                end
                R_LOW: begin
                    if (cnt == LOW_LAST) begin
                        o_byte     <= i_data_in;
                        o_byte_vld <= 1'b1;
                        o_rd_n     <= 1'b1;
                        cnt        <= 8'd0;
                        state      <= R_HIGH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                R_HIGH: begin
                    if (cnt == HIGH_LAST) begin
                        cnt   <= 8'd0;
                        state <= R_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    o_rd_n <= 1'b1;
                    state  <= R_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/ft232h_frame_rx.sv
// FT232H frame receiver: header hunt, cmd + payload assembly, checksum check
// and inter-byte timeout. Only validated frames reach o_cmd/o_data.
module ft232h_frame_rx
    import ft232h_pkg::*;
#(
    parameter int          DATA_BYTES  = 4,
    parameter int          USE_HEADER  = 1,
    parameter logic [7:0]  HEADER_BYTE = 8'hAB,
    parameter int          USE_CHKSUM  = 1,
    parameter int          RD_LOW_CYC  = 2,
    parameter int          RD_HIGH_CYC = 2,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ft232h_frame_rx_if.master     bus
);
    localparam int         DW       = 8 * DATA_BYTES;
    localparam frm_state_e START_ST = (USE_HEADER != 0) ? F_HUNT : F_CMD;
    localparam logic [3:0] IDX_LAST = 4'(DATA_BYTES - 1);

    logic [7:0]  rx_byte;
    logic        byte_vld;
    logic        rd_n;
    logic [1:0]  rd_state;

    frm_state_e  frm_state;
    logic [7:0]  sh_cmd;
    logic [DW-1:0] sh_data;
    logic [DW-1:0] data_next;
    logic [7:0]  acc;
    logic [3:0]  idx;
    logic [15:0] gap_cnt;
    logic        timeout_hit;

    logic [7:0]    cmd_q;
    logic [DW-1:0] data_q;
    logic          ready_q;
    logic          err_q;
    logic [1:0]    code_q;

    ft232h_byte_rd #(
        .RD_LOW_CYC  (RD_LOW_CYC),
        .RD_HIGH_CYC (RD_HIGH_CYC)
    ) u_byte_rd (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rxf_n    (bus.i_rxf_n),
        .i_data_in  (bus.i_data_in),
        .o_rd_n     (rd_n),
        .o_byte     (rx_byte),
        .o_byte_vld (byte_vld),
        .o_state    (rd_state)
    );

    assign bus.o_rd_n        = rd_n;
    assign bus.o_cmd         = cmd_q;
    assign bus.o_data        = data_q;
    assign bus.o_data_ready  = ready_q;
    assign bus.o_frame_err   = err_q;
    assign bus.o_err_code    = code_q;
    assign bus.dbg_rd_state  = rd_state;
    assign bus.dbg_frm_state = frm_state;

    // A byte arriving in the same cycle always beats the timeout.
    assign timeout_hit = (TIMEOUT_CYC != 16'd0) && (frm_state != START_ST) &&
                         !byte_vld && (gap_cnt == TIMEOUT_CYC - 16'd1);

    // Shadow payload with the current byte merged in, first byte in the MSBs.
    always_comb begin
        data_next = sh_data;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (byte_vld && frm_state == F_DATA && idx == 4'(DATA_BYTES - 1 - i))
                data_next[8*i +: 8] = rx_byte;
        end
    end

    // Frame FSM, checksum accumulator, gap counter and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frm_state <= START_ST;
            sh_cmd    <= 8'd0;
            sh_data   <= '0;
            acc       <= 8'd0;
            idx       <= 4'd0;
            gap_cnt   <= 16'd0;
            cmd_q     <= 8'd0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if (byte_vld)
                gap_cnt <= 16'd0;
            else if (frm_state != START_ST && TIMEOUT_CYC != 16'd0)
                gap_cnt <= gap_cnt + 16'd1;

            if (timeout_hit) begin
                frm_state <= START_ST;
                gap_cnt   <= 16'd0;
                err_q     <= 1'b1;
                code_q    <= ERR_TIMEOUT;
            end else if (byte_vld) begin
                case (frm_state)
                    F_HUNT: begin
                        if (rx_byte == HEADER_BYTE)
                            frm_state <= F_CMD;
                    end
                    F_CMD: begin
                        sh_cmd    <= rx_byte;
                        acc       <= rx_byte;
                        idx       <= 4'd0;
                        frm_state <= F_DATA;
                    end
                    F_DATA: begin
                        sh_data <= data_next;
                        acc     <= acc + rx_byte;
                        if (idx == IDX_LAST) begin
                            if (USE_CHKSUM != 0) begin
                                frm_state <= F_CHK;
                            end else begin
                                cmd_q     <= sh_cmd;
                                data_q    <= data_next;
                                ready_q   <= 1'b1;
                                frm_state <= START_ST;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    F_CHK: begin
                        if (rx_byte == acc) begin
                            cmd_q   <= sh_cmd;
                            data_q  <= sh_data;
                            ready_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= ERR_CHKSUM;
                        end
                        frm_state <= START_ST;
                    end
                    default: frm_state <= START_ST;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ft232h_frame_rx.sv
// Testbench for ft232h_frame_rx: directed byte streams into two instances
// (default configuration, and DATA_BYTES=2 without header/checksum), with a
// scoreboard queue per instance checked by independent monitors.
module tb_ft232h_frame_rx;
    import ft232h_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // {lat_check, is_err, code[1:0], cmd[7:0], data[31:0]}
    logic [43:0] exp_q0[$];
    logic [43:0] exp_q1[$];
    int          last_rise[2];
    int          last_evt[2];
    logic [7:0]  prev_cmd[2];
    logic [31:0] prev_data[2];
    logic [7:0]  fr[$];

    ft232h_frame_rx_if #(.DATA_BYTES(4)) bus0();
    ft232h_frame_rx_if #(.DATA_BYTES(2)) bus1();

    ft232h_frame_rx dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    ft232h_frame_rx #(
        .DATA_BYTES (2),
        .USE_HEADER (0),
        .USE_CHKSUM (0)
    ) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic get_rd(input int inst);
        return (inst == 0) ? bus0.o_rd_n : bus1.o_rd_n;
    endfunction

    task automatic set_pins(input int inst, input logic rxf, input logic [7:0] d);
        if (inst == 0) begin
            bus0.i_rxf_n = rxf;
            bus0.i_data_in = d;
        end else begin
            bus1.i_rxf_n = rxf;
            bus1.i_data_in = d;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents one byte like the FT232H FIFO: RXF# low with D valid until the
    // receiver completes an RD# strobe; also checks the RD# low width.
    task automatic send_byte(input int inst, input logic [7:0] b);
        int n;
        int low;
        set_pins(inst, 1'b0, b);
        n = 0;
        while (get_rd(inst) !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) check($sformatf("rd_fall_wait%0d", inst), 1, 0);
        low = 0;
        while (get_rd(inst) === 1'b0 && low < 200) begin
            tick(1);
            low++;
        end
        check($sformatf("rd_low_cycles%0d", inst), low, 2);
        last_rise[inst] = cyc;
        set_pins(inst, 1'b1, b);
    endtask

    task automatic send_frame(input int inst, input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(inst, bs[i]);
    endtask

    task automatic expect_good(input int inst, input logic [7:0] c, input logic [31:0] d);
        if (inst == 0) exp_q0.push_back({1'b1, 1'b0, ERR_NONE, c, d});
        else           exp_q1.push_back({1'b1, 1'b0, ERR_NONE, c, d});
        prev_cmd[inst]  = c;
        prev_data[inst] = d;
    endtask

    task automatic expect_err(input int inst, input logic [1:0] code, input logic lat);
        if (inst == 0) exp_q0.push_back({lat, 1'b1, code, prev_cmd[inst], prev_data[inst]});
        else           exp_q1.push_back({lat, 1'b1, code, prev_cmd[inst], prev_data[inst]});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        check("drain_q0_empty", exp_q0.size(), 0);
        check("drain_q1_empty", exp_q1.size(), 0);
    endtask

    // ---------------- scoreboard / monitors ----------------
    task automatic mon_step(input int inst, input logic rdy, input logic err,
                            input logic [1:0] code, input logic [7:0] c, input logic [31:0] d);
        logic [43:0] e;
        bit          have;
        if (!(rdy || err)) return;
        last_evt[inst] = cyc;
        check($sformatf("rdy_err_exclusive%0d", inst), rdy & err, 0);
        have = 0;
        e = '0;
        if (inst == 0 && exp_q0.size() != 0) begin
            e = exp_q0.pop_front();
            have = 1;
        end else if (inst == 1 && exp_q1.size() != 0) begin
            e = exp_q1.pop_front();
            have = 1;
        end
        if (!have) begin
            check($sformatf("unexpected_event%0d", inst), {rdy, err}, 0);
            return;
        end
        check($sformatf("event_kind%0d", inst), err, e[42]);
        if (err) check($sformatf("err_code%0d", inst), code, e[41:40]);
        check($sformatf("cmd%0d", inst), c, e[39:32]);
        check($sformatf("data%0d", inst), d, e[31:0]);
        if (e[43]) check($sformatf("latency%0d", inst), cyc - last_rise[inst], 1);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n)
            mon_step(0, bus0.o_data_ready, bus0.o_frame_err, bus0.o_err_code,
                     bus0.o_cmd, bus0.o_data);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n)
            mon_step(1, bus1.o_data_ready, bus1.o_frame_err, bus1.o_err_code,
                     bus1.o_cmd, {16'h0, bus1.o_data});
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int gap;
        last_rise = '{0, 0};
        last_evt  = '{0, 0};
        prev_cmd  = '{8'h0, 8'h0};
        prev_data = '{32'h0, 32'h0};
        set_pins(0, 1'b1, 8'h00);
        set_pins(1, 1'b1, 8'h00);
        rst_n = 1'b0;
        tick(3);

        // Reset values
        check("rst_rd_n", bus0.o_rd_n, 1);
        check("rst_cmd", bus0.o_cmd, 0);
        check("rst_data", bus0.o_data, 0);
        check("rst_ready", bus0.o_data_ready, 0);
        check("rst_err", bus0.o_frame_err, 0);
        check("rst_code", bus0.o_err_code, 0);
        check("rst_frm_state", bus0.dbg_frm_state, F_HUNT);
        check("rst1_frm_state", bus1.dbg_frm_state, F_CMD);
        rst_n = 1'b1;
        tick(2);

        // Basic frame: checksum 10+01+02+03+04 = 1A
        expect_good(0, 8'h10, 32'h01020304);
        fr = '{8'hAB, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h1A};
        send_frame(0, fr);
        drain(20);

        // Junk before the header is dropped silently; sum 20+05 = 25
        expect_good(0, 8'h20, 32'h00000005);
        fr = '{8'h55, 8'h77, 8'hAB, 8'h20, 8'h00, 8'h00, 8'h00, 8'h05, 8'h25};
        send_frame(0, fr);
        drain(20);

        // Bad checksum: error code 2, outputs keep the 20/00000005 frame
        expect_err(0, ERR_CHKSUM, 1'b1);
        fr = '{8'hAB, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
        send_frame(0, fr);
        drain(20);
        expect_good(0, 8'h10, 32'h01020304);
        fr = '{8'hAB, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h1A};
        send_frame(0, fr);
        drain(20);

        // Inter-byte timeout after AB 10 01
        expect_err(0, ERR_TIMEOUT, 1'b0);
        fr = '{8'hAB, 8'h10, 8'h01};
        send_frame(0, fr);
        n = 0;
        while (exp_q0.size() != 0 && n < 60000) begin
            tick(1);
            n++;
        end
        check("timeout_seen", exp_q0.size(), 0);
        gap = last_evt[0] - last_rise[0];
        check("timeout_gap_in_window", (gap >= 50000 && gap <= 50002), 1);
        check("timeout_back_to_hunt", bus0.dbg_frm_state, F_HUNT);
        check("timeout_code_held", bus0.o_err_code, ERR_TIMEOUT);

        // Checksum wrap: 11+FF+FF+00+01 = 0x210 -> 10
        expect_good(0, 8'h11, 32'hFFFF0001);
        fr = '{8'hAB, 8'h11, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h10};
        send_frame(0, fr);
        drain(20);

        // Second configuration: no header, no checksum, 2 data bytes
        expect_good(1, 8'h33, 32'h0000AA55);
        fr = '{8'h33, 8'hAA, 8'h55};
        send_frame(1, fr);
        drain(20);

        // Reset in the middle of a read
        fr = '{8'hAB, 8'h10};
        send_frame(0, fr);
        set_pins(0, 1'b0, 8'h01);
        n = 0;
        while (bus0.o_rd_n !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        check("midread_rd_low", bus0.o_rd_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd_n", bus0.o_rd_n, 1);
        check("midrst_cmd", bus0.o_cmd, 0);
        check("midrst_data", bus0.o_data, 0);
        check("midrst_ready", bus0.o_data_ready, 0);
        check("midrst_err", bus0.o_frame_err, 0);
        check("midrst_code", bus0.o_err_code, 0);
        check("midrst1_cmd", bus1.o_cmd, 0);
        check("midrst_frm_state", bus0.dbg_frm_state, F_HUNT);
        check("midrst_rd_state", bus0.dbg_rd_state, R_IDLE);
        set_pins(0, 1'b1, 8'h00);
        prev_cmd  = '{8'h0, 8'h0};
        prev_data = '{32'h0, 32'h0};
        tick(3);
        #2 rst_n = 1'b1;
        tick(2);

        // Clean frames after reset: sum 42+01*4 = 46
        expect_good(0, 8'h42, 32'h01010101);
        fr = '{8'hAB, 8'h42, 8'h01, 8'h01, 8'h01, 8'h01, 8'h46};
        send_frame(0, fr);
        expect_good(1, 8'h01, 32'h00000203);
        fr = '{8'h01, 8'h02, 8'h03};
        send_frame(1, fr);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
